hybrid_gshare_predictor: RTL and testbench

Next-generation direction predictor for the fetch stage.
- Combines a gshare table (PC xor global history) and a bimodal table (PC only), selected per branch by a PC-indexed chooser table.
- Owns the speculative global history register (GHR) internally, with repair on mispredict.
- Provides per-slot predictions for a FETCH_WIDTH-wide fetch group. Branch identity (is_branch) and targets come from the external BTB.

---
 rtl/hybrid_gshare_predictor.sv | 110 +++++++++++
 tb/tb_hybrid_gshare_predictor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_gshare_predictor.sv
// hybrid_gshare_predictor: gshare + bimodal direction predictor with PC-indexed chooser and speculative GHR
module hybrid_gshare_predictor #(
    parameter int FETCH_WIDTH  = 4,
    parameter int BHR_DEPTH    = 8,
    parameter int BIM_IDX_BITS = 8,
    parameter int CHO_IDX_BITS = 8,
    parameter int CTR_BITS     = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           rd_valid,
    input  logic [31:0]                    rd_pc,
    input  logic [FETCH_WIDTH-1:0]         rd_is_branch,
    output logic [FETCH_WIDTH-1:0]         pred_taken,
    output logic                           pred_any_taken,
    output logic [$clog2(FETCH_WIDTH)-1:0] pred_slot,
    output logic [BHR_DEPTH-1:0]           pred_bhr,
    input  logic                           wr_en,
    input  logic [31:0]                    wr_pc,
    input  logic [BHR_DEPTH-1:0]           wr_bhr,
    input  logic                           wr_taken,
    input  logic                           wr_mispredict
);
    localparam int SW = $clog2(FETCH_WIDTH);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [BHR_DEPTH-1:0]    ghr_q, ghr_d;
    logic [CTR_BITS-1:0]     gsh_q [2**BHR_DEPTH];
    logic [CTR_BITS-1:0]     bim_q [2**BIM_IDX_BITS];
    logic [1:0]              cho_q [2**CHO_IDX_BITS];
    logic                    shift_en;
    logic                    unused_pc;
    logic [BHR_DEPTH-1:0]    wg;
    logic [BIM_IDX_BITS-1:0] wb;
    logic [CHO_IDX_BITS-1:0] wc;
    logic [CTR_BITS-1:0]     g_cur, b_cur, g_nxt, b_nxt;
    logic [1:0]              c_cur, c_nxt;
    logic                    gp, bp;

    assign unused_pc = ^{rd_pc[1:0], wr_pc};

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        logic [29:0]             w;
        logic [BHR_DEPTH-1:0]    gi;
        logic [BIM_IDX_BITS-1:0] bi;
        logic [CHO_IDX_BITS-1:0] ci;
        logic                    unused_w;
        assign w        = rd_pc[31:2] + 30'(i);
        assign gi       = w[BHR_DEPTH-1:0] ^ ghr_q;
        assign bi       = w[BIM_IDX_BITS-1:0];
        assign ci       = w[CHO_IDX_BITS-1:0];
        assign unused_w = ^w;
        assign pred_taken[i] = rd_valid & rd_is_branch[i] &
                               (cho_q[ci][1] ? gsh_q[gi][CTR_BITS-1] : bim_q[bi][CTR_BITS-1]);
    end

    assign pred_any_taken = |pred_taken;
    assign pred_bhr       = ghr_q;

    // first taken slot, and whether any branch up to it (or any at all if none taken) was fetched
    always_comb begin
        pred_slot = '0;
        shift_en  = 1'b0;
        for (int s = FETCH_WIDTH - 1; s >= 0; s--) if (pred_taken[s]) pred_slot = SW'(s);
        for (int s = 0; s < FETCH_WIDTH; s++)
            if (!pred_any_taken || SW'(s) <= pred_slot) shift_en = shift_en | rd_is_branch[s];
        shift_en = shift_en & rd_valid;
    end

    // mispredict repair beats the speculative fetch shift
    always_comb begin
        ghr_d = (wr_en & wr_mispredict) ? {wr_bhr[BHR_DEPTH-2:0], wr_taken} :
                shift_en                ? {ghr_q[BHR_DEPTH-2:0], pred_any_taken} : ghr_q;
    end

    // resolve-side counter updates computed from the snapshot history
    always_comb begin
        wg    = wr_pc[BHR_DEPTH+1:2] ^ wr_bhr;
        wb    = wr_pc[BIM_IDX_BITS+1:2];
        wc    = wr_pc[CHO_IDX_BITS+1:2];
        g_cur = gsh_q[wg];
        b_cur = bim_q[wb];
        c_cur = cho_q[wc];
        gp    = g_cur[CTR_BITS-1];
        bp    = b_cur[CTR_BITS-1];
        g_nxt = wr_taken ? ((g_cur == CTR_MAX) ? g_cur : g_cur + 1'b1) : ((g_cur == '0) ? g_cur : g_cur - 1'b1);
        b_nxt = wr_taken ? ((b_cur == CTR_MAX) ? b_cur : b_cur + 1'b1) : ((b_cur == '0) ? b_cur : b_cur - 1'b1);
        c_nxt = (gp == bp)       ? c_cur :
                (gp == wr_taken) ? ((c_cur == 2'd3) ? c_cur : c_cur + 2'd1) :
                                   ((c_cur == 2'd0) ? c_cur : c_cur - 2'd1);
    end

    // history register and the three tables, all cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
            for (int k = 0; k < 2**BHR_DEPTH; k++) gsh_q[k] <= CTR_INIT;
            for (int k = 0; k < 2**BIM_IDX_BITS; k++) bim_q[k] <= CTR_INIT;
            for (int k = 0; k < 2**CHO_IDX_BITS; k++) cho_q[k] <= 2'b01;
        end else begin
            ghr_q <= ghr_d;
            if (wr_en) begin
                gsh_q[wg] <= g_nxt;
                bim_q[wb] <= b_nxt;
                cho_q[wc] <= c_nxt;
            end
        end
    end
endmodule

// File: tb/tb_hybrid_gshare_predictor.sv
// tb_hybrid_gshare_predictor: directed and randomized checks of the hybrid predictor against a table model
module tb_hybrid_gshare_predictor;
    localparam int H  = 2;
    localparam int MX = 3;

    logic        clock = 0, reset = 0, rd_valid = 0;
    logic [31:0] rd_pc = 0, wr_pc = 0;
    logic [3:0]  rd_is_branch = 0, pred_taken;
    logic        pred_any_taken, wr_en = 0, wr_taken = 0, wr_mispredict = 0;
    logic [1:0]  pred_slot;
    logic [7:0]  pred_bhr, wr_bhr = 0;

    int n_cmp = 0, n_bad = 0;
    int m_gsh [256], m_bim [256], m_cho [256];
    int m_ghr;

    hybrid_gshare_predictor dut (
        .clock(clock), .reset(reset), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_is_branch(rd_is_branch), .pred_taken(pred_taken), .pred_any_taken(pred_any_taken),
        .pred_slot(pred_slot), .pred_bhr(pred_bhr), .wr_en(wr_en), .wr_pc(wr_pc),
        .wr_bhr(wr_bhr), .wr_taken(wr_taken), .wr_mispredict(wr_mispredict)
    );

    always #5 clock = ~clock;

    task automatic m_reset();
        for (int k = 0; k < 256; k++) begin
            m_gsh[k] = 1;
            m_bim[k] = 1;
            m_cho[k] = 1;
        end
        m_ghr = 0;
    endtask

    function automatic logic [3:0] m_taken();
        logic [3:0] t = '0;
        for (int i = 0; i < 4; i++) begin
            int w = int'(((rd_pc + 32'(4 * i)) >> 2) & 32'hFF);
            int g = w ^ m_ghr;
            bit p = (m_cho[w] >= 2) ? (m_gsh[g] >= H) : (m_bim[w] >= H);
            t[i] = rd_valid && rd_is_branch[i] && p;
        end
        return t;
    endfunction

    function automatic logic [1:0] first_of(logic [3:0] t);
        logic [1:0] f = 0;
        for (int i = 3; i >= 0; i--) if (t[i]) f = 2'(i);
        return f;
    endfunction

    task automatic rd(logic v, logic [31:0] pc, logic [3:0] br);
        rd_valid = v;
        rd_pc = pc;
        rd_is_branch = br;
    endtask

    task automatic wr(logic en, logic [31:0] pc, logic [7:0] bhr, logic tk, logic mis);
        wr_en = en;
        wr_pc = pc;
        wr_bhr = bhr;
        wr_taken = tk;
        wr_mispredict = mis;
    endtask

    task automatic step();
        logic [3:0] t = m_taken();
        int f = int'(first_of(t));
        bit br = 0;
        int ng = m_ghr;
        int w = int'((wr_pc >> 2) & 32'hFF);
        int gi = w ^ int'(wr_bhr);
        bit gp = m_gsh[gi] >= H;
        bit bp = m_bim[w] >= H;
        for (int i = 0; i < 4; i++) if (t == 0 || i <= f) br |= rd_is_branch[i];
        if (wr_en && wr_mispredict) ng = ((int'(wr_bhr) << 1) | int'(wr_taken)) & 255;
        else if (rd_valid && br) ng = ((m_ghr << 1) | int'(t != 0)) & 255;
        @(posedge clock);
        if (wr_en) begin
            m_gsh[gi] = wr_taken ? (m_gsh[gi] < MX ? m_gsh[gi] + 1 : MX) : (m_gsh[gi] > 0 ? m_gsh[gi] - 1 : 0);
            m_bim[w]  = wr_taken ? (m_bim[w] < MX ? m_bim[w] + 1 : MX) : (m_bim[w] > 0 ? m_bim[w] - 1 : 0);
            if (gp != bp) m_cho[w] = (gp == wr_taken) ? (m_cho[w] < 3 ? m_cho[w] + 1 : 3) : (m_cho[w] > 0 ? m_cho[w] - 1 : 0);
        end
        m_ghr = ng;
        @(negedge clock);
    endtask

    task automatic test_reset();
        rd(1, 32'h100, 4'hF);
        #1;
        n_cmp++;
        if ({pred_taken, pred_any_taken, pred_slot, pred_bhr} !== 15'h0) begin
            $display("FAIL reset_outputs got taken=%b any=%b slot=%0d bhr=%h want all zero", pred_taken, pred_any_taken, pred_slot, pred_bhr);
            n_bad++;
        end
        @(negedge clock);
        reset = 1;
        m_reset();
    endtask

    task automatic test_first_read();
        rd(1, 32'h100, 4'b0010);
        #1;
        n_cmp++;
        if ({pred_taken, pred_any_taken, pred_slot, pred_bhr} !== 15'h0 || pred_taken !== m_taken()) begin
            $display("FAIL first_read got taken=%b any=%b bhr=%h want 0000/0/00", pred_taken, pred_any_taken, pred_bhr);
            n_bad++;
        end
        step();
        rd(0, 0, 0);
        #1;
        n_cmp++;
        if (pred_bhr !== 8'h00 || pred_bhr !== 8'(m_ghr)) begin
            $display("FAIL first_shift got bhr=%h want 00", pred_bhr);
            n_bad++;
        end
    endtask

    task automatic test_bimodal_train();
        wr(1, 32'h104, 8'h00, 1, 0);
        step();
        step();
        wr(0, 0, 0, 0, 0);
        rd(1, 32'h100, 4'b0010);
        #1;
        n_cmp++;
        if (pred_taken !== 4'b0010 || pred_slot !== 2'd1 || pred_any_taken !== 1'b1 || pred_taken !== m_taken()) begin
            $display("FAIL bim_train got taken=%b slot=%0d any=%b want 0010/1/1", pred_taken, pred_slot, pred_any_taken);
            n_bad++;
        end
        step();
        rd(0, 0, 0);
        #1;
        n_cmp++;
        if (pred_bhr !== 8'h01 || pred_bhr !== 8'(m_ghr)) begin
            $display("FAIL bim_shift got bhr=%h want 01", pred_bhr);
            n_bad++;
        end
    endtask

    task automatic test_saturation();
        wr(1, 32'h300, 8'h00, 1, 0);
        for (int k = 0; k < 5; k++) step();
        wr(1, 32'h300, 8'h00, 0, 0);
        step();
        wr(0, 0, 0, 0, 0);
        rd(1, 32'h300, 4'b0001);
        #1;
        n_cmp++;
        if (pred_taken !== 4'b0001 || pred_taken !== m_taken()) begin
            $display("FAIL sat_one_nt got taken=%b want 0001", pred_taken);
            n_bad++;
        end
        rd(0, 0, 0);
        wr(1, 32'h300, 8'h00, 0, 0);
        step();
        wr(0, 0, 0, 0, 0);
        rd(1, 32'h300, 4'b0001);
        #1;
        n_cmp++;
        if (pred_taken !== 4'b0000 || pred_taken !== m_taken()) begin
            $display("FAIL sat_two_nt got taken=%b want 0000", pred_taken);
            n_bad++;
        end
        rd(0, 0, 0);
    endtask

    task automatic test_repair_priority();
        rd(1, 32'h100, 4'b0010);
        wr(1, 32'h500, 8'hA5, 0, 1);
        #1;
        n_cmp++;
        if (pred_any_taken !== 1'b1 || pred_taken !== m_taken()) begin
            $display("FAIL repair_pre got any=%b taken=%b want 1", pred_any_taken, pred_taken);
            n_bad++;
        end
        step();
        rd(0, 0, 0);
        wr(0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (pred_bhr !== 8'h4A || pred_bhr !== 8'(m_ghr)) begin
            $display("FAIL repair_ghr got bhr=%h want 4a", pred_bhr);
            n_bad++;
        end
    endtask

    task automatic test_chooser();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) wr(1, 32'h200, 8'h01, 1, 0);
            else wr(1, 32'h200, 8'h00, 0, 0);
            step();
        end
        wr(1, 32'h9F0, 8'h00, 1, 1);
        step();
        wr(0, 0, 0, 0, 0);
        rd(1, 32'h200, 4'b0001);
        #1;
        n_cmp++;
        if (pred_bhr !== 8'h01 || pred_taken !== 4'b0001 || pred_taken !== m_taken()) begin
            $display("FAIL chooser got taken=%b bhr=%h want 0001/01", pred_taken, pred_bhr);
            n_bad++;
        end
        rd(0, 0, 0);
    endtask

    task automatic test_multi_slot();
        wr(1, 32'h404, 8'h00, 1, 0);
        step();
        step();
        wr(1, 32'h40C, 8'h00, 1, 0);
        step();
        step();
        wr(0, 0, 0, 0, 0);
        rd(1, 32'h400, 4'b1011);
        #1;
        n_cmp++;
        if (pred_taken !== 4'b1010 || pred_slot !== 2'd1 || pred_any_taken !== 1'b1 || pred_taken !== m_taken()) begin
            $display("FAIL multi_slot got taken=%b slot=%0d any=%b want 1010/1/1", pred_taken, pred_slot, pred_any_taken);
            n_bad++;
        end
        #2;
        reset = 0;
        #1;
        n_cmp++;
        if ({pred_taken, pred_any_taken, pred_slot, pred_bhr} !== 15'h0) begin
            $display("FAIL async_reset got taken=%b any=%b slot=%0d bhr=%h want all zero", pred_taken, pred_any_taken, pred_slot, pred_bhr);
            n_bad++;
        end
        m_reset();
        @(negedge clock);
        reset = 1;
        n_cmp++;
        if (pred_taken !== 4'b0000) begin
            $display("FAIL reset_tables got taken=%b want 0000", pred_taken);
            n_bad++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            logic [3:0] et;
            rd(1'($urandom), 32'h1000 + 32'(4 * $urandom_range(0, 63)), 4'($urandom));
            wr(1'($urandom), 32'h1000 + 32'(4 * $urandom_range(0, 63)),
               ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom_range(0, 3)),
               1'($urandom), $urandom_range(0, 3) == 0);
            #1;
            et = m_taken();
            n_cmp++;
            if ({pred_taken, pred_any_taken, pred_slot, pred_bhr} !== {et, |et, first_of(et), 8'(m_ghr)}) begin
                $display("FAIL random[%0d] got taken=%b any=%b slot=%0d bhr=%h want %b/%b/%0d/%h",
                         k, pred_taken, pred_any_taken, pred_slot, pred_bhr, et, |et, first_of(et), 8'(m_ghr));
                n_bad++;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_bimodal_train();
        test_saturation();
        test_repair_priority();
        test_chooser();
        test_multi_slot();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
